// File: rtl/icache_fill.sv
// Instruction-cache fill controller: passes hit data through, issues one LOAD
// at a time for missing blocks, and writes returning blocks into the cache.
module icache_fill #(
  parameter int MSHR_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] proc2Icache_addr_0,
  input  logic [63:0] proc2Icache_addr_1,
  input  logic [63:0] proc2Icache_addr_2,
  output logic [63:0] Icache_data_0,
  output logic [63:0] Icache_data_1,
  output logic [63:0] Icache_data_2,
  output logic [2:0]  Icache_valid_out,
  output logic [4:0]  cache_rd_idx_0,
  output logic [4:0]  cache_rd_idx_1,
  output logic [4:0]  cache_rd_idx_2,
  output logic [7:0]  cache_rd_tag_0,
  output logic [7:0]  cache_rd_tag_1,
  output logic [7:0]  cache_rd_tag_2,
  input  logic [63:0] cache_rd_data_0,
  input  logic [63:0] cache_rd_data_1,
  input  logic [63:0] cache_rd_data_2,
  input  logic [2:0]  cache_rd_valid,
  output logic        cache_wr_en,
  output logic [4:0]  cache_wr_idx,
  output logic [7:0]  cache_wr_tag,
  output logic [63:0] cache_wr_data,
  output logic [1:0]  proc2Imem_command,
  output logic [63:0] proc2Imem_addr,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag
);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e                  state_q, state_d;
  logic [4:0]              req_idx_q, req_idx_d;
  logic [7:0]              req_tag_q, req_tag_d;
  logic [MSHR_DEPTH-1:0]   mshr_vld_q, mshr_vld_d;
  logic [3:0]              mshr_mtag_q [MSHR_DEPTH];
  logic [3:0]              mshr_mtag_d [MSHR_DEPTH];
  logic [4:0]              mshr_idx_q  [MSHR_DEPTH];
  logic [4:0]              mshr_idx_d  [MSHR_DEPTH];
  logic [7:0]              mshr_tag_q  [MSHR_DEPTH];
  logic [7:0]              mshr_tag_d  [MSHR_DEPTH];

  logic [4:0]              lane_idx [3];
  logic [7:0]              lane_tag [3];
  logic [2:0]              pending;
  logic                    cand_found;
  logic [4:0]              cand_idx;
  logic [7:0]              cand_tag;
  logic                    fill_hit;
  logic [4:0]              fill_idx;
  logic [7:0]              fill_tag;
  logic [MSHR_DEPTH-1:0]   rel_oh;
  logic [MSHR_DEPTH-1:0]   alloc_oh;
  logic                    alloc_found;
  logic                    any_free;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{proc2Icache_addr_0[63:16], proc2Icache_addr_0[2:0],
                              proc2Icache_addr_1[63:16], proc2Icache_addr_1[2:0],
                              proc2Icache_addr_2[63:16], proc2Icache_addr_2[2:0]};

  always_comb begin
    lane_idx[0] = proc2Icache_addr_0[7:3];
    lane_idx[1] = proc2Icache_addr_1[7:3];
    lane_idx[2] = proc2Icache_addr_2[7:3];
    lane_tag[0] = proc2Icache_addr_0[15:8];
    lane_tag[1] = proc2Icache_addr_1[15:8];
    lane_tag[2] = proc2Icache_addr_2[15:8];
  end

  assign cache_rd_idx_0   = lane_idx[0];
  assign cache_rd_idx_1   = lane_idx[1];
  assign cache_rd_idx_2   = lane_idx[2];
  assign cache_rd_tag_0   = lane_tag[0];
  assign cache_rd_tag_1   = lane_tag[1];
  assign cache_rd_tag_2   = lane_tag[2];
  assign Icache_data_0    = cache_rd_data_0;
  assign Icache_data_1    = cache_rd_data_1;
  assign Icache_data_2    = cache_rd_data_2;
  assign Icache_valid_out = cache_rd_valid;

  // Returning data: find the entry owning this memory tag; tag 0 means no data.
  always_comb begin
    rel_oh   = '0;
    fill_hit = 1'b0;
    fill_idx = '0;
    fill_tag = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (!fill_hit && mshr_vld_q[i] && (Imem2proc_tag != 4'd0) &&
          (mshr_mtag_q[i] == Imem2proc_tag)) begin
        fill_hit  = 1'b1;
        rel_oh[i] = 1'b1;
        fill_idx  = mshr_idx_q[i];
        fill_tag  = mshr_tag_q[i];
      end
    end
  end

  assign cache_wr_en   = fill_hit;
  assign cache_wr_idx  = fill_idx;
  assign cache_wr_tag  = fill_tag;
  assign cache_wr_data = Imem2proc_data;

  // Oldest missing lane whose block is neither outstanding nor arriving now.
  always_comb begin
    pending    = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_tag   = '0;
    for (int k = 0; k < 3; k++) begin
      if (fill_hit && (fill_idx == lane_idx[k]) && (fill_tag == lane_tag[k]))
        pending[k] = 1'b1;
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (mshr_vld_q[i] && (mshr_idx_q[i] == lane_idx[k]) && (mshr_tag_q[i] == lane_tag[k]))
          pending[k] = 1'b1;
      end
      if (!cand_found && !cache_rd_valid[k] && !pending[k]) begin
        cand_found = 1'b1;
        cand_idx   = lane_idx[k];
        cand_tag   = lane_tag[k];
      end
    end
  end

  // Allocation ignores the entry being released so a same-cycle fill cannot clobber it.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (!alloc_found && !mshr_vld_q[i]) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  assign any_free = |(~mshr_vld_q | rel_oh);

  always_comb begin
    state_d           = state_q;
    req_idx_d         = req_idx_q;
    req_tag_d         = req_tag_q;
    mshr_vld_d        = mshr_vld_q & ~rel_oh;
    mshr_mtag_d       = mshr_mtag_q;
    mshr_idx_d        = mshr_idx_q;
    mshr_tag_d        = mshr_tag_q;
    proc2Imem_command = CMD_NONE;
    proc2Imem_addr    = '0;
    case (state_q)
      S_IDLE: begin
        if (cand_found && any_free) begin
          state_d   = S_REQ;
          req_idx_d = cand_idx;
          req_tag_d = cand_tag;
        end
      end
      S_REQ: begin
        proc2Imem_command = CMD_LOAD;
        proc2Imem_addr    = {48'b0, req_tag_q, req_idx_q, 3'b0};
        if (Imem2proc_response != 4'd0) begin
          state_d = S_IDLE;
          for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (alloc_oh[i]) begin
              mshr_vld_d[i]  = 1'b1;
              mshr_mtag_d[i] = Imem2proc_response;
              mshr_idx_d[i]  = req_idx_q;
              mshr_tag_d[i]  = req_tag_q;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mshr_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      mshr_vld_q <= mshr_vld_d;
    end
  end

  // Payload registers are qualified by state/valid bits, so they need no reset.
  always_ff @(posedge clock) begin
    req_idx_q   <= req_idx_d;
    req_tag_q   <= req_tag_d;
    mshr_mtag_q <= mshr_mtag_d;
    mshr_idx_q  <= mshr_idx_d;
    mshr_tag_q  <= mshr_tag_d;
  end

endmodule

// File: doc/icache_fill.md
# icache_fill

Instruction-cache fill controller sitting directly upstream of the 32-entry, 3-read-port instruction cache memory. It splits the three fetch addresses into cache index and tag, and returns hit data and per-lane valid bits to fetch. On a miss it issues one LOAD at a time to memory and tracks outstanding loads by memory tag in a small miss table. Returning blocks are written into the cache through its single write port.

## Interface
- `MSHR_DEPTH`, 4: outstanding fills tracked; legal range 1–15.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `proc2Icache_addr_0/1/2` in 64 each: fetch addresses. Lane 0 is the oldest.
- `Icache_data_0/1/2` out 64 each: instruction block per lane, equal to `cache_rd_data_k`.
- `Icache_valid_out` out 3: bit k asserts when lane k hits.
- `cache_rd_idx_0/1/2` out 5 each: address bits [7:3].
- `cache_rd_tag_0/1/2` out 8 each: address bits [15:8].
- `cache_rd_data_0/1/2` in 64 each: read data from the cache.
- `cache_rd_valid` in 3: per-lane hit from the cache.
- `cache_wr_en` out 1: cache write strobe.
- `cache_wr_idx` out 5: cache write index.
- `cache_wr_tag` out 8: cache write tag.
- `cache_wr_data` out 64: cache write data.
- `proc2Imem_command` out 2: 0 = NONE, 1 = LOAD.
- `proc2Imem_addr` out 64: request address, {48'b0, tag, idx, 3'b0}.
- `Imem2proc_response` in 4: nonzero = request accepted with that tag; 0 = rejected or none.
- `Imem2proc_data` in 64: returned block.
- `Imem2proc_tag` in 4: nonzero = data valid for that tag.

## Operation
- Hit path (combinational):
  - `cache_rd_idx_k`/`cache_rd_tag_k` come from `proc2Icache_addr_k`.
  - `Icache_valid_out = cache_rd_valid`.
- Miss table: `MSHR_DEPTH` entries of {valid, mem_tag[3:0], idx[4:0], tag[7:0]}.
- Request register: {state, idx, tag}. States are IDLE and REQ.
- IDLE:
  - Select the lowest-numbered lane k with `cache_rd_valid[k]=0`.
  - Skip a lane if its {idx, tag} is already pending: it matches a valid table entry, or it matches the block being filled this cycle.
  - If a candidate exists and at least one table entry is free, latch {idx, tag} and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Drive `proc2Imem_command=LOAD` with the latched address.
  - If `Imem2proc_response!=0`, write {1, response, idx, tag} into the lowest free entry and return to IDLE.
  - If the response is 0, stay in REQ and retry the same address next cycle.
- In IDLE, `proc2Imem_command=NONE` and `proc2Imem_addr=0`.
- Fill:
  - When `Imem2proc_tag!=0` matches a valid entry, drive `cache_wr_en=1` in the same cycle, with the entry's idx/tag and `cache_wr_data=Imem2proc_data`.
  - That entry is cleared at the edge.
  - A tag matching no entry is ignored (`cache_wr_en=0`).
- Free-entry check in IDLE counts the entry being released that cycle as free. The REQ slot is reserved, so acceptance always finds a free entry.
- Stale data with an unmatched tag after reset is ignored.

## Timing
- Reset (`reset` low): table invalid, state IDLE, command NONE, address 0, `cache_wr_en=0`. Data and valid outputs follow cache inputs combinationally.
- Hit latency: 0 cycles (combinational through the cache).
- A miss seen in cycle t gives LOAD on `proc2Imem_command` in cycle t+1.
- Acceptance in cycle t gives the entry valid from t+1, and the next miss may be latched in t+1.
- Data tag matching in cycle t: `cache_wr_en` is high in t, and the lane hits from t+1.
- Response acceptance and fill with a different tag in the same cycle: both are processed. Allocation uses the lowest free entry excluding the one being released.
- Reset asserted mid-REQ: command drops to NONE asynchronously and no entry is retained.

## Test plan
- Cold miss:
  - Stimulus: reset, then lane0 addr 0x108 misses; memory accepts with tag 3 two cycles later; data 0xDEAD tag 3 arrives four cycles after that.
  - Required: LOAD 0x108 is held until acceptance; then one write with idx=1, tag=1, data=0xDEAD; `Icache_valid_out[0]=1` on the next cycle.
- Retry:
  - Stimulus: response=0 for 3 cycles, then response=5.
  - Required: the address is stable across the retries; the entry records tag 5.
- Duplicate suppression:
  - Stimulus: all three lanes miss on the same block 0x200.
  - Required: exactly one LOAD is issued.
- Table full:
  - Stimulus: four accepted misses with no data returned, then a fifth distinct miss.
  - Required: no LOAD for the fifth; it issues in the cycle after the first fill returns.
- Unknown tag and same-cycle events:
  - Stimulus: tag 9 data with no matching entry → required: no write.
  - Stimulus: acceptance plus fill of another entry in the same cycle → required: both are handled correctly.
- Async reset during REQ:
  - Stimulus: assert reset while in REQ, then data returns for an old tag.
  - Required: command is NONE immediately; the old-tag data produces no cache write.
